rr_mux2_stream: RTL and testbench

- Two-input stream merger that sits directly upstream of the team's 2:1 mux datapath.
- Arbitrates two valid/ready packet streams round-robin and generates the select for the 2:1 mux, held for a whole packet.
- Registers the selected beat into a single output stage.
- Output is one merged stream tagged with its source, ready for the downstream consumer.

---
 rtl/rr_mux2_pkg.sv | 31 +++
 rtl/stream_out_reg.sv | 46 ++++
 rtl/rr_mux2_stream.sv | 112 +++++++++++
 tb/tb_rr_mux2_stream.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux2_pkg.sv
// Shared encodings for the two-input round-robin stream merger:
// packet-lock FSM states, source ids and small arbitration helpers.
package rr_mux2_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t LOCK0 = 2'd1;
  localparam state_t LOCK1 = 2'd2;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Lock state that holds the mux on the given source until its last beat.
  function automatic state_t lock_state(input logic src);
    return (src == SRC1) ? LOCK1 : LOCK0;
  endfunction

  function automatic logic idle_pick(input logic v0, input logic v1, input logic prio);
    logic pick;
    if (v0 && v1) begin
      pick = prio;
    end else if (v1) begin
      pick = SRC1;
    end else begin
      pick = SRC0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single output register stage for the merged stream; reloads whenever it is
// empty or being drained, otherwise holds its beat stable.
module stream_out_reg #(
  parameter int BEAT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [BEAT_W-1:0] load_beat,
  input  logic              out_ready,
  output logic              load_en,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_valid
);

  logic              valid_reg, valid_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;

  assign load_en = !valid_reg || out_ready;

  always_comb begin
    valid_next = valid_reg;
    beat_next  = beat_reg;
    if (load_en) begin
      valid_next = load_valid;
      // Payload is only replaced by a real beat; an empty slot keeps old data.
      if (load_valid) begin
        beat_next = load_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      beat_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      beat_reg  <= beat_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_beat  = beat_reg;

endmodule

// File: rtl/rr_mux2_stream.sv
// Two-input round-robin packet merger: arbitrates per packet, drives the 2:1
// mux select (reported as out_src) and registers the chosen beat.
module rr_mux2_stream
  import rr_mux2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready
);

  localparam int BEAT_W = WIDTH + 2;

  state_t           state_reg, state_next;
  logic             prio_reg, prio_next;
  logic             grant;
  logic             load_en;
  logic             accept;
  logic [1:0]       valid_vec;
  logic [1:0]       last_vec;
  logic [1:0]       ready_vec;
  logic [WIDTH-1:0] data_vec [2];
  logic [BEAT_W-1:0] sel_beat;
  logic [BEAT_W-1:0] out_beat;

  assign valid_vec   = {in1_valid, in0_valid};
  assign last_vec    = {in1_last, in0_last};
  assign data_vec[0] = in0_data;
  assign data_vec[1] = in1_data;

  // The select stays pinned to the owning source for the whole packet.
  always_comb begin
    unique case (state_reg)
      LOCK0:   grant = SRC0;
      LOCK1:   grant = SRC1;
      default: grant = idle_pick(in0_valid, in1_valid, prio_reg);
    endcase
  end

  // While locked, ready is offered even without valid so a bubble keeps the lock.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n && load_en && (grant == 1'(gi)) &&
                             ((state_reg != IDLE) || valid_vec[gi]);
    end
  endgenerate

  assign in0_ready = ready_vec[0];
  assign in1_ready = ready_vec[1];
  assign accept    = |(ready_vec & valid_vec);
  assign sel_beat  = {grant, last_vec[grant], data_vec[grant]};

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    if (accept) begin
      if (last_vec[grant]) begin
        state_next = IDLE;
        prio_next  = ~grant;
      end else begin
        state_next = lock_state(grant);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      prio_reg  <= SRC0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
    end
  end

  stream_out_reg #(
    .BEAT_W(BEAT_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(accept),
    .load_beat (sel_beat),
    .out_ready (out_ready),
    .load_en   (load_en),
    .out_beat  (out_beat),
    .out_valid (out_valid)
  );

  assign out_data = out_beat[WIDTH-1:0];
  assign out_last = out_beat[WIDTH];
  assign out_src  = out_beat[WIDTH+1];

  // Invariants: at most one input is ever offered ready, and a stalled beat holds.
  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(in0_ready && in1_ready));
  a_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_beat)));

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Directed bench for rr_mux2_stream: queue-driven sources, a packet-level
// reference model checked every cycle, and hand-computed beat sequences.
module tb_rr_mux2_stream;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             in0_valid, in0_last, in0_ready;
  logic             in1_valid, in1_last, in1_ready;
  logic             out_valid, out_last, out_src, out_ready;

  always #5 clk = ~clk;

  rr_mux2_stream #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_data (in0_data),
    .in0_valid(in0_valid),
    .in0_last (in0_last),
    .in0_ready(in0_ready),
    .in1_data (in1_data),
    .in1_valid(in1_valid),
    .in1_last (in1_last),
    .in1_ready(in1_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic       l;
  } item_t;

  typedef struct {
    int         cyc;
    logic       src;
    logic [7:0] d;
    logic       l;
  } beat_t;

  item_t q0[$];
  item_t q1[$];
  beat_t log_q[$];
  bit    shown0 = 0, shown1 = 0;
  bit    acc0 = 0, acc1 = 0;
  int    acc_cnt0 = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  bit    started = 0;

  // Packet-level model: who owns the mux, whose turn is next, what sits in the output slot.
  int         m_owner = -1;
  int         m_turn  = 0;
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic       m_ol = 1'b0;
  logic       m_os = 1'b0;
  int         pick;
  bit         can_load, e0, e1, tv;
  logic [7:0] td;
  logic       tl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cyc++;
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("out_data", out_data, m_od);
        check("out_last", out_last, m_ol);
        check("out_src", out_src, m_os);
      end
      can_load = !m_ov || out_ready;
      pick = -1;
      if (rst_n && can_load) begin
        if (m_owner >= 0) pick = m_owner;
        else if (in0_valid && in1_valid) pick = m_turn;
        else if (in0_valid) pick = 0;
        else if (in1_valid) pick = 1;
      end
      e0 = (pick == 0);
      e1 = (pick == 1);
      check("in0_ready", in0_ready, e0);
      check("in1_ready", in1_ready, e1);
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      if (acc0) acc_cnt0++;
      if (out_valid && out_ready) log_q.push_back('{cyc, out_src, out_data, out_last});
      // Predict the state after the coming clock edge.
      if (!rst_n) begin
        m_owner = -1; m_turn = 0;
        m_ov = 0; m_od = 8'h00; m_ol = 0; m_os = 0;
      end else if (can_load) begin
        tv = (pick == 0) ? in0_valid : (pick == 1) ? in1_valid : 1'b0;
        td = (pick == 1) ? in1_data : in0_data;
        tl = (pick == 1) ? in1_last : in0_last;
        m_ov = tv;
        if (tv) begin
          m_od = td; m_ol = tl; m_os = pick[0];
          if (tl) begin
            m_owner = -1;
            m_turn  = 1 - pick;
          end else begin
            m_owner = pick;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (shown0 && q0.size() > 0 && (acc0 || !q0[0].v)) q0.delete(0);
    if (shown1 && q1.size() > 0 && (acc1 || !q1[0].v)) q1.delete(0);
    shown0 = q0.size() > 0;
    shown1 = q1.size() > 0;
    in0_valid = shown0 && q0[0].v;
    in0_data  = in0_valid ? q0[0].d : 8'h00;
    in0_last  = in0_valid && q0[0].l;
    in1_valid = shown1 && q1[0].v;
    in1_data  = in1_valid ? q1[0].d : 8'h00;
    in1_last  = in1_valid && q1[0].l;
    #1;
  endtask

  task automatic run_drain(input int max_cycles);
    int n;
    n = 0;
    tick();
    while ((q0.size() > 0 || q1.size() > 0 || out_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    if (n >= max_cycles) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d cycles, required < %0d", n, max_cycles);
    end
  endtask

  task automatic check_beat(input int idx, input logic [7:0] d, input logic s);
    if (idx >= log_q.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL beat%0d: missing, required data %0h src %0d", idx, d, s);
    end else begin
      check($sformatf("beat%0d_data", idx), log_q[idx].d, d);
      check($sformatf("beat%0d_src", idx), log_q[idx].src, s);
    end
  endtask

  task automatic check_gap(input int a, input int b, input int gap);
    if (b >= log_q.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL gap%0d_%0d: beat missing, required gap %0d", a, b, gap);
    end else begin
      check($sformatf("gap%0d_%0d", a, b), log_q[b].cyc - log_q[a].cyc, gap);
    end
  endtask

  initial begin
    int base, c0, n;
    rst_n = 1'b0; out_ready = 1'b1;
    in0_valid = 0; in0_data = 0; in0_last = 0;
    in1_valid = 0; in1_data = 0; in1_last = 0;

    // Reset with both streams valid, then alternation of single-beat packets.
    q0.push_back('{1, 8'hA0, 1}); q0.push_back('{1, 8'hA1, 1});
    q1.push_back('{1, 8'hB0, 1}); q1.push_back('{1, 8'hB1, 1});
    tick();
    started = 1;
    tick();
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("first_grant_in0", in0_ready, 1);
    check("first_grant_in1", in1_ready, 0);
    base = log_q.size();
    run_drain(30);
    check_beat(base + 0, 8'hA0, 0);
    check_beat(base + 1, 8'hB0, 1);
    check_beat(base + 2, 8'hA1, 0);
    check_beat(base + 3, 8'hB1, 1);
    check_gap(base + 0, base + 3, 3);

    // Packet lock: in0's 3-beat packet completes before in1 is served.
    base = log_q.size();
    q0.push_back('{1, 8'h11, 0}); q0.push_back('{1, 8'h12, 0}); q0.push_back('{1, 8'h13, 1});
    q1.push_back('{1, 8'h21, 1});
    run_drain(30);
    check_beat(base + 0, 8'h11, 0);
    check_beat(base + 1, 8'h12, 0);
    check_beat(base + 2, 8'h13, 0);
    check_beat(base + 3, 8'h21, 1);

    // Backpressure holds 0x55, release passes it and the next beat back-to-back.
    base = log_q.size();
    out_ready = 1'b0;
    q0.push_back('{1, 8'h55, 1}); q0.push_back('{1, 8'h56, 1});
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("hold_data", out_data, 8'h55);
      check("hold_valid", out_valid, 1);
      check("hold_in0_ready", in0_ready, 0);
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    run_drain(30);
    check_beat(base + 0, 8'h55, 0);
    check_beat(base + 1, 8'h56, 0);
    check_gap(base + 0, base + 1, 1);

    // Locked bubble: in1 keeps the lock over 3 idle cycles, in0 waits.
    base = log_q.size();
    q1.push_back('{1, 8'h31, 0});
    for (int i = 0; i < 3; i++) q1.push_back('{0, 8'h00, 0});
    q1.push_back('{1, 8'h32, 1});
    q0.push_back('{1, 8'h41, 1});
    run_drain(30);
    check_beat(base + 0, 8'h31, 1);
    check_beat(base + 1, 8'h32, 1);
    check_beat(base + 2, 8'h41, 0);
    check_gap(base + 0, base + 1, 4);
    check_gap(base + 1, base + 2, 1);

    // Reset after the 2nd beat of a 4-beat packet, then in1-only traffic.
    base = log_q.size();
    c0 = acc_cnt0;
    q0.push_back('{1, 8'h61, 0}); q0.push_back('{1, 8'h62, 0});
    q0.push_back('{1, 8'h63, 0}); q0.push_back('{1, 8'h64, 1});
    n = 0;
    while (acc_cnt0 < c0 + 2 && n < 40) begin
      tick();
      n++;
    end
    check("mid_pkt_accepts", acc_cnt0 - c0, 2);
    rst_n = 1'b0;
    q0.delete(); shown0 = 0;
    in0_valid = 0; in0_data = 0; in0_last = 0;
    tick();
    tick();
    check("midrst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    q1.push_back('{1, 8'h71, 1});
    tick();
    check("after_rst_in1_ready", in1_ready, 1);
    run_drain(30);
    check_beat(base + 0, 8'h61, 0);
    check_beat(base + 1, 8'h62, 0);
    check_beat(base + 2, 8'h71, 1);
    check("midrst_log_len", log_q.size() - base, 3);

    // A completed in0 packet leaves prio=1; reset must put it back to 0.
    base = log_q.size();
    q0.push_back('{1, 8'h7A, 1});
    run_drain(30);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q0.push_back('{1, 8'h81, 1});
    q1.push_back('{1, 8'h91, 1});
    run_drain(30);
    check_beat(base + 0, 8'h7A, 0);
    check_beat(base + 1, 8'h81, 0);
    check_beat(base + 2, 8'h91, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
